dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port byte-addressed data memory (`dmemory`). It shares the memory between requester 0 (pipeline MEM stage) and requester 1 (debug/loader port). It grants one access per cycle, drives the memory port from the winner, and checks alignment. It registers each access's completion into a one-cycle response pulse. Requester 0 has fixed priority, and a starvation counter guarantees requester 1 forward progress.

---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one request/grant handshake
// with a registered completion response.
interface dmem_arbiter_if;
  logic        req;
  logic        rw;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, rw, size, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, rw, size, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority arbiter for the single-port data memory: requester 0 wins
// unless requester 1 has lost STARVE_LIMIT consecutive contended cycles.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_arbiter_if.slave        m0,
  dmem_arbiter_if.slave        m1,
  output logic                 mem_read_write,
  output logic [2:0]           mem_access_size,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_data_in,
  input  logic [31:0]          mem_data_out
);

  // Size codes: bits [1:0] give width (byte/half/word), bit 2 marks unsigned loads.
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_q, starve_d;
  logic        gnt0, gnt1;
  logic        sel_rw;
  logic [2:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        misaligned;
  logic [31:0] load_data;

  logic        rvalid0_q, rvalid0_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic        err0_q, err0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        err1_q, err1_d;

  // Grants are suppressed during reset so nothing reaches the memory.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (m1.req && ((starve_q == LIMIT) || !m0.req)) begin
        gnt1 = 1'b1;
      end else if (m0.req) begin
        gnt0 = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt1 || !m1.req) begin
      starve_d = 4'd0;
    end else if (gnt0 && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    sel_rw    = 1'b0;
    sel_size  = 3'd0;
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    if (gnt0) begin
      sel_rw    = m0.rw;
      sel_size  = m0.size;
      sel_addr  = m0.addr;
      sel_wdata = m0.wdata;
    end else if (gnt1) begin
      sel_rw    = m1.rw;
      sel_size  = m1.size;
      sel_addr  = m1.addr;
      sel_wdata = m1.wdata;
    end
  end

  // Unknown size codes fall through as aligned.
  always_comb begin
    misaligned = 1'b0;
    case (sel_size)
      SZ_H, SZ_HU: misaligned = sel_addr[0];
      SZ_W:        misaligned = |sel_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

  assign mem_read_write  = sel_rw & ~misaligned;
  assign mem_access_size = sel_size;
  assign mem_address     = sel_addr;
  assign mem_data_in     = sel_wdata;

  assign load_data = (!sel_rw && !misaligned) ? mem_data_out : 32'd0;

  always_comb begin
    rvalid0_d = gnt0;
    rdata0_d  = rdata0_q;
    err0_d    = err0_q;
    rvalid1_d = gnt1;
    rdata1_d  = rdata1_q;
    err1_d    = err1_q;
    if (gnt0) begin
      rdata0_d = load_data;
      err0_d   = misaligned;
    end
    if (gnt1) begin
      rdata1_d = load_data;
      err1_d   = misaligned;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q  <= 4'd0;
      rvalid0_q <= 1'b0;
      rdata0_q  <= 32'd0;
      err0_q    <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata1_q  <= 32'd0;
      err1_q    <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      rvalid0_q <= rvalid0_d;
      rdata0_q  <= rdata0_d;
      err0_q    <= err0_d;
      rvalid1_q <= rvalid1_d;
      rdata1_q  <= rdata1_d;
      err1_q    <= err1_d;
    end
  end

  // A response pending when reset rises is dropped rather than presented.
  assign m0.gnt    = gnt0;
  assign m0.rvalid = rvalid0_q & ~reset;
  assign m0.rdata  = rdata0_q;
  assign m0.err    = err0_q;
  assign m1.gnt    = gnt1;
  assign m1.rvalid = rvalid1_q & ~reset;
  assign m1.rdata  = rdata1_q;
  assign m1.err    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-requester traffic,
// scored against a byte-array reference memory and an arbitration model.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
  localparam int MEM_BYTES = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read_write;
  logic [2:0]  mem_access_size;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  always #5 clock = ~clock;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock           (clock),
    .reset           (reset),
    .m0              (m0_if),
    .m1              (m1_if),
    .mem_read_write  (mem_read_write),
    .mem_access_size (mem_access_size),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out)
  );

  // Data memory: combinational little-endian read, store on rising edge.
  logic [7:0]  mem_bytes [MEM_BYTES];
  logic [11:0] ma;
  always_comb begin
    ma = mem_address[11:0];
    case (mem_access_size)
      3'b000:  mem_data_out = {{24{mem_bytes[ma][7]}}, mem_bytes[ma]};
      3'b100:  mem_data_out = {24'd0, mem_bytes[ma]};
      3'b001:  mem_data_out = {{16{mem_bytes[ma + 12'd1][7]}}, mem_bytes[ma + 12'd1], mem_bytes[ma]};
      3'b101:  mem_data_out = {16'd0, mem_bytes[ma + 12'd1], mem_bytes[ma]};
      3'b010:  mem_data_out = {mem_bytes[ma + 12'd3], mem_bytes[ma + 12'd2],
                               mem_bytes[ma + 12'd1], mem_bytes[ma]};
      default: mem_data_out = 32'd0;
    endcase
  end
  always @(posedge clock) begin
    if (mem_read_write) begin
      case (mem_access_size)
        3'b000: mem_bytes[ma] <= mem_data_in[7:0];
        3'b001: begin
          mem_bytes[ma]         <= mem_data_in[7:0];
          mem_bytes[ma + 12'd1] <= mem_data_in[15:8];
        end
        3'b010: begin
          mem_bytes[ma]         <= mem_data_in[7:0];
          mem_bytes[ma + 12'd1] <= mem_data_in[15:8];
          mem_bytes[ma + 12'd2] <= mem_data_in[23:16];
          mem_bytes[ma + 12'd3] <= mem_data_in[31:24];
        end
        default: ;
      endcase
    end
  end

  // Reference model state
  logic [7:0] ref_mem [MEM_BYTES];
  int         losses = 0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         dut_win;
  bit         g0_seen, g1_seen;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t q0[$];
  resp_t q1[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] idx(int unsigned a);
    return 12'(a % MEM_BYTES);
  endfunction

  function automatic int unsigned ref_rd(int unsigned a, int unsigned n);
    int unsigned v = 0;
    for (int unsigned k = 0; k < n; k++) v += 32'(ref_mem[idx(a + k)]) << (8 * k);
    return v;
  endfunction

  function automatic logic [31:0] ref_load(int sz, int unsigned a);
    int unsigned v;
    case (sz)
      0: begin v = ref_rd(a, 1); return (v >= 128) ? v + 32'hFFFF_FF00 : v; end
      4: return ref_rd(a, 1);
      1: begin v = ref_rd(a, 2); return (v >= 32768) ? v + 32'hFFFF_0000 : v; end
      5: return ref_rd(a, 2);
      2: return ref_rd(a, 4);
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_store(int sz, int unsigned a, int unsigned data);
    int unsigned n;
    n = (sz == 0) ? 1 : (sz == 1) ? 2 : (sz == 2) ? 4 : 0;
    for (int unsigned k = 0; k < n; k++) ref_mem[idx(a + k)] = 8'((data >> (8 * k)) % 256);
  endtask

  function automatic bit ref_misaligned(int sz, int unsigned a);
    if ((sz == 1 || sz == 5) && (a % 2 != 0)) return 1'b1;
    if (sz == 2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic preload_word(int unsigned a, logic [31:0] w);
    for (int unsigned k = 0; k < 4; k++) begin
      mem_bytes[idx(a + k)] <= w[8*k +: 8];
      ref_mem[idx(a + k)]    = w[8*k +: 8];
    end
  endtask

  task automatic drive0(bit req, bit rw, logic [2:0] sz, logic [31:0] a, logic [31:0] d);
    m0_if.req = req; m0_if.rw = rw; m0_if.size = sz; m0_if.addr = a; m0_if.wdata = d;
  endtask

  task automatic drive1(bit req, bit rw, logic [2:0] sz, logic [31:0] a, logic [31:0] d);
    m1_if.req = req; m1_if.rw = rw; m1_if.size = sz; m1_if.addr = a; m1_if.wdata = d;
  endtask

  // One cycle: check combinational outputs at the falling edge, score the grant,
  // then return just after the next rising edge.
  task automatic tick();
    int          w;
    bit          rw, mis;
    int          sz;
    logic [31:0] ad, wd;
    resp_t       r;
    @(negedge clock);
    w = -1;
    if (!reset) begin
      if (m1_if.req && (losses == LIMIT || !m0_if.req)) w = 1;
      else if (m0_if.req) w = 0;
    end
    g0_seen = m0_if.gnt;
    g1_seen = m1_if.gnt;
    dut_win = m0_if.gnt ? 0 : (m1_if.gnt ? 1 : -1);
    check("m0_gnt", 32'(m0_if.gnt), 32'(w == 0));
    check("m1_gnt", 32'(m1_if.gnt), 32'(w == 1));
    rw = 1'b0; sz = 0; ad = 32'd0; wd = 32'd0; mis = 1'b0;
    if (w == 0) begin rw = m0_if.rw; sz = int'(m0_if.size); ad = m0_if.addr; wd = m0_if.wdata; end
    if (w == 1) begin rw = m1_if.rw; sz = int'(m1_if.size); ad = m1_if.addr; wd = m1_if.wdata; end
    if (w >= 0) mis = ref_misaligned(sz, ad);
    check("mem_read_write", 32'(mem_read_write), 32'(rw && !mis));
    check("mem_access_size", 32'(mem_access_size), 32'(sz));
    check("mem_address", mem_address, ad);
    check("mem_data_in", mem_data_in, wd);
    if (w >= 0) begin
      r.due   = cyc + 1;
      r.err   = mis;
      r.rdata = (!rw && !mis) ? ref_load(sz, ad) : 32'd0;
      if (rw && !mis) ref_store(sz, ad, wd);
      if (w == 0) q0.push_back(r); else q1.push_back(r);
    end
    if (reset) losses = 0;
    else if (w == 0 && m1_if.req) losses++;
    else if (w == 1 || !m1_if.req) losses = 0;
    @(posedge clock);
    #1;
  endtask

  // Response monitor
  always @(negedge clock) begin
    resp_t r;
    if (m0_if.rvalid) begin
      if (q0.size() == 0) check("m0_spurious_rvalid", 32'(m0_if.rvalid), 32'd0);
      else begin
        r = q0.pop_front();
        check("m0_rvalid_cycle", 32'(cyc), 32'(r.due));
        check("m0_rdata", m0_if.rdata, r.rdata);
        check("m0_err", 32'(m0_if.err), 32'(r.err));
      end
    end else if (q0.size() != 0 && q0[0].due <= cyc) begin
      check("m0_rvalid_missing", 32'(m0_if.rvalid), 32'd1);
      void'(q0.pop_front());
    end
    if (m1_if.rvalid) begin
      if (q1.size() == 0) check("m1_spurious_rvalid", 32'(m1_if.rvalid), 32'd0);
      else begin
        r = q1.pop_front();
        check("m1_rvalid_cycle", 32'(cyc), 32'(r.due));
        check("m1_rdata", m1_if.rdata, r.rdata);
        check("m1_err", 32'(m1_if.err), 32'(r.err));
      end
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      check("m1_rvalid_missing", 32'(m1_if.rvalid), 32'd1);
      void'(q1.pop_front());
    end
  end

  initial begin
    bit hold0, hold1;
    logic [7:0] v;
    for (int i = 0; i < MEM_BYTES; i++) begin
      v = 8'($urandom);
      mem_bytes[i] <= v;
      ref_mem[i]    = v;
    end
    preload_word(32'h100, 32'hDEAD_BEEF);
    preload_word(32'h080, 32'hCAFE_F00D);
    preload_word(32'h040, 32'hA5A5_A5A5);
    reset = 1'b1;
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive1(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    check("reset_m0_rdata", m0_if.rdata, 32'd0);
    check("reset_m0_err", 32'(m0_if.err), 32'd0);
    check("reset_m1_rdata", m1_if.rdata, 32'd0);
    check("reset_m1_err", 32'(m1_if.err), 32'd0);

    // Single LW from requester 0
    drive0(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
    tick();
    check("lw_gnt", 32'(g0_seen), 32'd1);
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("lw_rvalid", 32'(m0_if.rvalid), 32'd1);
    check("lw_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    check("lw_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
    tick();

    // Continuous contention: four m0 wins, then one m1 win, repeating
    drive0(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
    drive1(1'b1, 1'b0, 3'b010, 32'h080, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("contend_%0d", k), 32'(dut_win), (k % 5 == 4) ? 32'd1 : 32'd0);
    end
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive1(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    tick();

    // Store by m1 then byte loads by m0 on following cycles
    drive1(1'b1, 1'b1, 3'b010, 32'h40, 32'h1234_5678);
    tick();
    drive1(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive0(1'b1, 1'b0, 3'b000, 32'h43, 32'd0);
    tick();
    check("lb43_rdata", m0_if.rdata, 32'h0000_0012);
    drive0(1'b1, 1'b0, 3'b000, 32'h40, 32'd0);
    tick();
    check("lb40_rdata", m0_if.rdata, 32'h0000_0078);

    // Misaligned halfword store must not commit
    drive0(1'b1, 1'b1, 3'b001, 32'h41, 32'h0000_FFFF);
    tick();
    check("sh_err", 32'(m0_if.err), 32'd1);
    check("sh_rdata", m0_if.rdata, 32'd0);
    drive0(1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
    tick();
    check("sh_word_intact", m0_if.rdata, 32'h1234_5678);
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    tick();

    // Store attempted during reset is ignored
    reset = 1'b1;
    drive0(1'b1, 1'b1, 3'b010, 32'h80, 32'h1111_1111);
    tick();
    check("rst_no_gnt", 32'(g0_seen), 32'd0);
    tick();
    check("rst_no_rvalid", 32'(m0_if.rvalid), 32'd0);
    reset = 1'b0;
    drive0(1'b1, 1'b0, 3'b010, 32'h80, 32'd0);
    tick();
    check("rst_word_intact", m0_if.rdata, 32'hCAFE_F00D);
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    // Idle bus
    repeat (3) begin
      tick();
      check("idle_addr", mem_address, 32'd0);
      check("idle_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    end

    // Random traffic; each requester holds a request until granted
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!hold0) begin
        if ($urandom_range(0, 99) < 70) begin
          drive0(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom & 32'hFFFF_F000) | (32'h40 + 32'($urandom_range(0, 31))), $urandom);
          hold0 = 1'b1;
        end else drive0(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      end
      if (!hold1) begin
        if ($urandom_range(0, 99) < 60) begin
          drive1(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom & 32'hFFFF_F000) | (32'h40 + 32'($urandom_range(0, 31))), $urandom);
          hold1 = 1'b1;
        end else drive1(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      end
      tick();
      if (g0_seen) hold0 = 1'b0;
      if (g1_seen) hold1 = 1'b0;
    end
    drive0(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive1(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) tick();
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
